// File: rtl/serial_io_sequencer.sv
// Serial IO sequencer: CPU IO commands -> TX FIFO -> UART, and UART RX -> 16-bit responses.
// Latency: SEND write, response and fifo_sclr one cycle after accept; >=4 cycles per TX byte; cmd_ready low during serial reset or SEND into a full FIFO.
`timescale 1ns/1ps
module serial_io_sequencer #(
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [3:0]  cmd,
    input  logic [7:0]  cmd_data,
    output logic        cmd_ready,
    output logic [15:0] resp_data,
    output logic        resp_valid,
    output logic        fifo_wrreq,
    output logic [7:0]  fifo_din,
    output logic        fifo_rdreq,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_empty,
    input  logic        fifo_full,
    output logic        fifo_sclr,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_error,
    output logic        uart_reset
);

    localparam logic [3:0] CMD_RESET  = 4'b0001;
    localparam logic [3:0] CMD_SEND   = 4'b0010;
    localparam logic [3:0] CMD_RECV   = 4'b0011;
    localparam logic [3:0] CMD_STATUS = 4'b0100;
    localparam logic [3:0] RST_LOAD   = RST_CYCLES[3:0];

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_FETCH,
        TX_LOAD,
        TX_SEND
    } tx_state_t;

    tx_state_t   tx_state;
    tx_state_t   tx_state_nxt;
    logic [3:0]  rst_cnt;
    logic        in_rst;
    logic        accept;
    logic        acc_reset;
    logic        acc_send;
    logic        acc_recv;
    logic        acc_status;
    logic        tx_busy;
    logic [7:0]  rx_hold;
    logic        rx_avail;
    logic        rx_overrun;
    logic        rx_err;

    assign in_rst     = (rst_cnt != 4'd0);
    assign uart_reset = in_rst;
    assign tx_busy    = (tx_state != TX_IDLE);

    assign cmd_ready  = !reset && !in_rst && !((cmd == CMD_SEND) && fifo_full);
    assign accept     = cmd_valid && cmd_ready;
    assign acc_reset  = accept && (cmd == CMD_RESET);
    assign acc_send   = accept && (cmd == CMD_SEND);
    assign acc_recv   = accept && (cmd == CMD_RECV);
    assign acc_status = accept && (cmd == CMD_STATUS);

    // uart_reset is the counter being non-zero, so it spans exactly RST_CYCLES cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            rst_cnt   <= 4'd0;
            fifo_sclr <= 1'b0;
        end else begin
            fifo_sclr <= acc_reset;
            if (acc_reset) begin
                rst_cnt <= RST_LOAD;
            end else if (in_rst) begin
                rst_cnt <= rst_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fifo_wrreq <= 1'b0;
            fifo_din   <= 8'd0;
        end else begin
            fifo_wrreq <= acc_send;
            if (acc_send) begin
                fifo_din <= cmd_data;
            end
        end
    end

    // A RECV coinciding with rx_valid returns the old byte and keeps the new one without overrun.
    always_ff @(posedge clock) begin
        if (reset || acc_reset) begin
            rx_hold    <= 8'd0;
            rx_avail   <= 1'b0;
            rx_overrun <= 1'b0;
            rx_err     <= 1'b0;
        end else if (!in_rst) begin
            if (rx_valid) begin
                rx_hold    <= rx_data;
                rx_avail   <= 1'b1;
                rx_overrun <= !acc_recv && (rx_overrun || rx_avail);
            end else if (acc_recv) begin
                rx_avail   <= 1'b0;
                rx_overrun <= 1'b0;
            end
            if (rx_error) begin
                rx_err <= 1'b1;
            end else if (acc_recv) begin
                rx_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_data  <= 16'd0;
        end else begin
            resp_valid <= acc_recv || acc_status;
            if (acc_recv) begin
                resp_data <= rx_avail ? {rx_overrun, rx_err, 6'b0, rx_hold} : 16'h8000;
            end else if (acc_status) begin
                resp_data <= {10'b0, tx_busy, rx_err, rx_overrun, rx_avail, fifo_full, fifo_empty};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || acc_reset) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_state_nxt;
        end
    end

    // No reads while the FIFO is being cleared, so a stale byte never reaches the UART.
    always_comb begin
        tx_state_nxt = tx_state;
        fifo_rdreq   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty && !reset && !in_rst && !acc_reset) begin
                    fifo_rdreq   = 1'b1;
                    tx_state_nxt = TX_FETCH;
                end
            end
            TX_FETCH: tx_state_nxt = TX_LOAD;
            TX_LOAD:  tx_state_nxt = TX_SEND;
            TX_SEND: begin
                if (tx_valid && tx_ready) begin
                    tx_state_nxt = TX_IDLE;
                end
            end
            default:  tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'd0;
        end else if (acc_reset) begin
            tx_valid <= 1'b0;
        end else if (tx_state == TX_LOAD) begin
            tx_data  <= fifo_dout;
            tx_valid <= 1'b1;
        end else if ((tx_state == TX_SEND) && tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_io_sequencer.sv
// Bench for serial_io_sequencer: directed scenarios then random traffic, all outputs
// compared each cycle against an event-level model with an attached TX FIFO model.
`timescale 1ns/1ps
module tb_serial_io_sequencer;

    localparam int RST   = 4;
    localparam int DEPTH = 4;
    localparam logic [3:0] C_RST  = 4'd1;
    localparam logic [3:0] C_SEND = 4'd2;
    localparam logic [3:0] C_RECV = 4'd3;
    localparam logic [3:0] C_STAT = 4'd4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd = 4'd0;
    logic [7:0]  cmd_data = 8'd0;
    logic        cmd_ready;
    logic [15:0] resp_data;
    logic        resp_valid;
    logic        fifo_wrreq;
    logic [7:0]  fifo_din;
    logic        fifo_rdreq;
    logic [7:0]  fifo_dout = 8'd0;
    logic        fifo_empty = 1'b1;
    logic        fifo_full = 1'b0;
    logic        fifo_sclr;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_error = 1'b0;
    logic        uart_reset;

    serial_io_sequencer #(.RST_CYCLES(RST)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .resp_data(resp_data), .resp_valid(resp_valid),
        .fifo_wrreq(fifo_wrreq), .fifo_din(fifo_din), .fifo_rdreq(fifo_rdreq),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_sclr(fifo_sclr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
        .uart_reset(uart_reset)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // reference model state
    int          rst_acc_cyc = -1000;
    bit          e_wr = 0, e_sclr = 0, e_rv = 0;
    logic [7:0]  e_din = 8'd0;
    logic [15:0] e_rdat = 16'd0;
    bit          busy = 0;
    int          tx_start = 0;
    logic [7:0]  tx_byte = 8'd0;
    bit          m_avail = 0, m_over = 0, m_err = 0;
    logic [7:0]  m_hold = 8'd0;
    logic [7:0]  fq[$];
    bit          force_full = 0;

    // observations
    bit          s_acc, s_wr, s_rd, s_sclr;
    logic [7:0]  s_din;
    logic [15:0] last_resp;
    logic [7:0]  last_tx;
    int          urst_seen = 0, sclr_seen = 0, nacc = 0;

    task automatic chk_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic fifo_flags();
        fifo_empty = (fq.size() == 0);
        fifo_full  = force_full || (fq.size() >= DEPTH);
    endtask

    task automatic step();
        bit e_urst, e_rdy, acc, e_rd, e_txv, clr, is_rst;
        @(negedge clock);
        e_urst = (cyc > rst_acc_cyc) && (cyc <= rst_acc_cyc + RST);
        e_rdy  = !reset && !e_urst && !((cmd == C_SEND) && fifo_full);
        acc    = cmd_valid && e_rdy;
        is_rst = acc && (cmd == C_RST);
        e_rd   = !reset && !e_urst && !is_rst && !busy && !fifo_empty;
        e_txv  = busy && (cyc >= tx_start + 3);

        chk_eq("cmd_ready", 16'(cmd_ready), 16'(e_rdy));
        chk_eq("uart_reset", 16'(uart_reset), 16'(e_urst));
        chk_eq("fifo_sclr", 16'(fifo_sclr), 16'(e_sclr));
        chk_eq("fifo_wrreq", 16'(fifo_wrreq), 16'(e_wr));
        if (e_wr) chk_eq("fifo_din", 16'(fifo_din), 16'(e_din));
        chk_eq("resp_valid", 16'(resp_valid), 16'(e_rv));
        if (e_rv) chk_eq("resp_data", resp_data, e_rdat);
        chk_eq("fifo_rdreq", 16'(fifo_rdreq), 16'(e_rd));
        chk_eq("tx_valid", 16'(tx_valid), 16'(e_txv));
        if (e_txv) chk_eq("tx_data", 16'(tx_data), 16'(tx_byte));

        s_acc  = cmd_valid && cmd_ready;
        s_wr   = fifo_wrreq;
        s_din  = fifo_din;
        s_rd   = fifo_rdreq;
        s_sclr = fifo_sclr;
        if (resp_valid) last_resp = resp_data;
        if (tx_valid && tx_ready) last_tx = tx_data;
        if (uart_reset) urst_seen++;
        if (fifo_sclr) sclr_seen++;

        if (reset) begin
            e_wr = 0; e_sclr = 0; e_rv = 0;
            m_avail = 0; m_over = 0; m_err = 0; m_hold = 8'd0;
            busy = 0; rst_acc_cyc = -1000;
        end else begin
            e_wr   = acc && (cmd == C_SEND);
            if (e_wr) e_din = cmd_data;
            e_sclr = is_rst;
            e_rv   = acc && ((cmd == C_RECV) || (cmd == C_STAT));
            if (acc && (cmd == C_RECV))
                e_rdat = m_avail ? {m_over, m_err, 6'b0, m_hold} : 16'h8000;
            else if (acc && (cmd == C_STAT))
                e_rdat = {10'b0, busy, m_err, m_over, m_avail, fifo_full, fifo_empty};

            if (is_rst) begin
                m_avail = 0; m_over = 0; m_err = 0; m_hold = 8'd0;
            end else if (!e_urst) begin
                clr = acc && (cmd == C_RECV);
                if (rx_valid) begin
                    m_over  = !clr && (m_over || m_avail);
                    m_hold  = rx_data;
                    m_avail = 1;
                end else if (clr) begin
                    m_avail = 0;
                    m_over  = 0;
                end
                if (rx_error) m_err = 1;
                else if (clr) m_err = 0;
            end

            if (is_rst) busy = 0;
            else if (e_rd) begin
                busy = 1; tx_start = cyc; tx_byte = fq[0];
            end else if (e_txv && tx_ready) busy = 0;

            if (is_rst) rst_acc_cyc = cyc;
        end

        @(posedge clock);
        #1;
        if (s_sclr) fq.delete();
        else begin
            if (s_rd && fq.size() > 0) fifo_dout = fq.pop_front();
            if (s_wr && fq.size() < DEPTH) fq.push_back(s_din);
        end
        fifo_flags();
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_cmd(input logic [3:0] c, input logic [7:0] d);
        int n = 0;
        cmd_valid = 1'b1; cmd = c; cmd_data = d;
        do begin
            step();
            n++;
        end while (!s_acc && n < 50);
        chk_eq("cmd_accepted", 16'(s_acc), 16'h1);
        cmd_valid = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_valid = 1'b1; rx_data = d;
        step();
        rx_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int r;
        fifo_flags();
        @(posedge clock);
        #1;
        idle(3);
        chk_eq("rst_resp_data", resp_data, 16'h0000);
        chk_eq("rst_tx_data", 16'(tx_data), 16'h0000);
        reset = 1'b0;
        idle(2);

        send_cmd(C_SEND, 8'h41);
        idle(8);
        chk_eq("tx_byte_41", 16'(last_tx), 16'h0041);

        cmd_valid = 1'b1; cmd = C_SEND; cmd_data = 8'h77;
        force_full = 1; fifo_flags();
        nacc = 0;
        repeat (3) begin step(); nacc += int'(s_acc); end
        chk_eq("full_blocks_send", 16'(nacc), 16'h0);
        force_full = 0; fifo_flags();
        step();
        chk_eq("send_after_full", 16'(s_acc), 16'h1);
        cmd_valid = 1'b0;
        idle(8);
        chk_eq("tx_byte_77", 16'(last_tx), 16'h0077);

        rx_pulse(8'h5A);
        last_resp = 'x; send_cmd(C_RECV, 8'h00); idle(1);
        chk_eq("recv_5a", last_resp, 16'h005A);
        last_resp = 'x; send_cmd(C_RECV, 8'h00); idle(1);
        chk_eq("recv_empty", last_resp, 16'h8000);

        rx_pulse(8'h11);
        rx_pulse(8'h22);
        last_resp = 'x; send_cmd(C_RECV, 8'h00); idle(1);
        chk_eq("recv_overrun", last_resp, 16'h8022);
        last_resp = 'x; send_cmd(C_STAT, 8'h00); idle(1);
        chk_eq("status_cleared", last_resp & 16'h000C, 16'h0000);

        tx_ready = 1'b0;
        send_cmd(C_SEND, 8'h99);
        idle(6);
        chk_eq("tx_held", 16'(tx_valid), 16'h1);
        urst_seen = 0; sclr_seen = 0;
        send_cmd(C_RST, 8'h00);
        chk_eq("tx_valid_drop", 16'(tx_valid), 16'h0);
        chk_eq("ready_low_urst", 16'(cmd_ready), 16'h0);
        idle(8);
        chk_eq("urst_len", 16'(urst_seen), 16'(RST));
        chk_eq("sclr_len", 16'(sclr_seen), 16'h1);
        tx_ready = 1'b1;

        rx_pulse(8'h10);
        rx_valid = 1'b1; rx_data = 8'h33;
        last_resp = 'x; send_cmd(C_RECV, 8'h00);
        rx_valid = 1'b0;
        idle(1);
        chk_eq("recv_same_cycle", last_resp, 16'h0010);
        last_resp = 'x; send_cmd(C_RECV, 8'h00); idle(1);
        chk_eq("recv_new_byte", last_resp, 16'h0033);

        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            r = int'($urandom_range(0, 31));
            if (r == 0)       cmd = C_RST;
            else if (r <= 12) cmd = C_SEND;
            else if (r <= 18) cmd = C_RECV;
            else if (r <= 24) cmd = C_STAT;
            else              cmd = 4'($urandom);
            cmd_data = 8'($urandom);
            tx_ready = ($urandom_range(0, 1) == 1);
            rx_valid = ($urandom_range(0, 5) == 0);
            rx_data  = 8'($urandom);
            rx_error = ($urandom_range(0, 19) == 0);
            step();
        end
        cmd_valid = 1'b0; rx_valid = 1'b0; rx_error = 1'b0; tx_ready = 1'b1;
        idle(40);
        chk_eq("fifo_drained", 16'(fq.size()), 16'h0);
        chk_eq("tx_idle_end", 16'(tx_valid), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_io_sequencer.md
Name: serial_io_sequencer

Overview:
- Sequences the serial peripheral on behalf of the CPU IO path.
- Accepts 4-bit IO commands with an 8-bit payload, pushes TX bytes into the external TX FIFO and drains that FIFO to the UART transmitter.
- Captures UART RX bytes into a holding register and returns RX data or status as 16-bit responses for the IO controller to drive onto the bus.
- Sits between the IO controller, the serial TX FIFO and the UART core.

Parameters:
- RST_CYCLES, 4: cycles uart_reset is held high after a RESET_SERIAL command; legal range 1..15.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd  in  4  command code: 4'b0001 RESET_SERIAL, 4'b0010 SEND, 4'b0011 RECV, 4'b0100 STATUS.
- cmd_data  in  8  SEND payload.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- resp_data  out  16  RECV/STATUS result.
- resp_valid  out  1  one-cycle pulse qualifying resp_data.
- fifo_wrreq  out  1  TX FIFO write strobe.
- fifo_din  out  8  TX FIFO write data.
- fifo_rdreq  out  1  TX FIFO read strobe.
- fifo_dout  in  8  TX FIFO read data, valid the cycle after fifo_rdreq.
- fifo_empty  in  1  TX FIFO empty.
- fifo_full  in  1  TX FIFO full.
- fifo_sclr  out  1  TX FIFO synchronous clear.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  UART transmitter ready; a transfer occurs when tx_valid&tx_ready.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle pulse qualifying rx_data.
- rx_error  in  1  UART framing error pulse.
- uart_reset  out  1  UART core reset.

Behaviour:
- Reset values: cmd_ready=0, resp_valid=0, resp_data=0, fifo_wrreq=0, fifo_rdreq=0, fifo_sclr=0, tx_valid=0, tx_data=0, uart_reset=0. RX state is cleared and the TX FSM enters IDLE. cmd_ready rises on the first cycle after reset deasserts.
- cmd_ready = 0 while the serial-reset sequence runs. Otherwise cmd_ready = !(cmd==SEND && fifo_full) (combinational on cmd).
- SEND accepted: fifo_wrreq=1 and fifo_din=cmd_data in the cycle after acceptance (registered, one-cycle pulse).
- RECV accepted:
  - resp_valid pulses on the next cycle.
  - resp_data = {rx_overrun, rx_err, 6'b0, rx_hold} if rx_avail is set, else 16'h8000 with the low byte 0.
  - Clears rx_avail, rx_overrun and rx_err.
- STATUS accepted: resp_valid pulses on the next cycle. resp_data = {10'b0, tx_busy, rx_err, rx_overrun, rx_avail, fifo_full, fifo_empty}, sampled at acceptance. tx_busy = TX FSM not in IDLE.
- Unknown cmd codes: accepted and ignored; no response.
- RESET_SERIAL accepted:
  - fifo_sclr pulses for 1 cycle.
  - uart_reset is held high for exactly RST_CYCLES cycles, starting the cycle after acceptance.
  - TX FSM is forced to IDLE, tx_valid=0, and RX state is cleared.
  - cmd_ready returns high the cycle after uart_reset falls.
  - rx_valid and rx_error are ignored while uart_reset=1.
- RX path:
  - rx_valid: rx_hold<=rx_data and rx_avail<=1. If rx_avail was already 1 and is not being cleared by a RECV in the same cycle, rx_overrun<=1 (newest byte kept).
  - rx_error sets sticky rx_err.
  - RECV and rx_valid in the same cycle: the response carries the old byte; the new byte is stored and rx_avail stays 1; no overrun.
- TX FSM:
  - IDLE: if !fifo_empty, assert fifo_rdreq for 1 cycle and go to FETCH.
  - FETCH: wait 1 cycle for fifo_dout, go to LOAD.
  - LOAD: tx_data<=fifo_dout, tx_valid<=1, go to SEND.
  - SEND: hold tx_data and tx_valid until tx_valid&tx_ready, then tx_valid<=0 and return to IDLE.
  - Minimum 4 cycles per byte. tx_data stays stable while tx_valid=1.
- A SEND fifo write and an FSM fifo read in the same cycle are legal.
- Reset or RESET_SERIAL overrides all of the above in any state.

Test Plan:
- Reset then SEND 0x41: fifo_wrreq pulses with fifo_din=0x41 one cycle after acceptance. The FIFO model goes non-empty, fifo_rdreq pulses, and tx_data=0x41 with tx_valid=1 three cycles later. With tx_ready=1, tx_valid drops after the handshake.
- fifo_full=1 with SEND presented: cmd_ready=0 and no fifo_wrreq. Deassert full: the command is accepted in that cycle and the write follows.
- rx_valid with 0x5A, then RECV: resp_data=0x005A and resp_valid pulses one cycle after acceptance. A second RECV returns 0x8000.
- Two rx_valid pulses (0x11, 0x22) then RECV: resp_data=0x8022. A following STATUS has bit3=0 and bit2=0.
- RESET_SERIAL while tx_valid=1 with tx_ready=0: fifo_sclr pulses and uart_reset is high for exactly 4 cycles. tx_valid goes to 0 the next cycle and cmd_ready is 0 until uart_reset falls.
- RECV on the same cycle as rx_valid 0x33, with 0x10 held: the response is 0x0010, then the next RECV returns 0x0033 with no overrun.
